// File: rtl/hc_sr04_top.sv
// HC-SR04 ultrasonic range finder top level.
// Fires periodic trigger pulses, measures the echo width in centimetres,
// converts the result to BCD by shift-add-3 and drives a multiplexed
// three-digit seven-segment display plus a "measuring" LED.
module hc_sr04_top #(
  parameter int BCD_DIGITS = 3,
  parameter int SSEG       = 7,
  parameter int MAX_RANGE  = 400,
  parameter int DST_SZ     = $clog2(MAX_RANGE),
  parameter int NUM_LEN    = 4,
  parameter int BCD_LEN    = BCD_DIGITS * NUM_LEN,
  parameter int STRB_DIV   = 2941,
  parameter int TRIG_LEN   = 500,
  parameter int MEAS_PER   = 3000000,
  parameter int REFR_DIV   = 50000
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  I_EN,
  input  logic                  I_ECHO,
  output logic                  O_TRIG,
  output logic [BCD_DIGITS-1:0] O_MUX_HEX,
  output logic [SSEG-1:0]       O_HEX,
  output logic                  O_FL
);

  localparam int PER_W  = $clog2(MEAS_PER);
  localparam int DIV_W  = $clog2(STRB_DIV);
  localparam int REF_W  = $clog2(REFR_DIV);
  localparam int SEL_W  = $clog2(BCD_DIGITS);
  localparam int ITER_W = $clog2(DST_SZ);
  localparam int SH_W   = BCD_LEN + DST_SZ;

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(MEAS_PER - 1);
  localparam logic [PER_W-1:0]  TRIG_END  = PER_W'(TRIG_LEN);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STRB_DIV - 1);
  localparam logic [DST_SZ-1:0] DST_MAX   = DST_SZ'(MAX_RANGE);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFR_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(BCD_DIGITS - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DST_SZ - 1);

  // Centimetre counter increment that sticks at the maximum range.
  function automatic logic [DST_SZ-1:0] sat_inc(input logic [DST_SZ-1:0] v);
    return (v >= DST_MAX) ? v : v + 1'b1;
  endfunction

  // One shift-add-3 step: correct every BCD digit >= 5, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0]    t;
    logic [NUM_LEN-1:0] dg;
    t = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      dg = t[DST_SZ + i*NUM_LEN +: NUM_LEN];
      if (dg > NUM_LEN'(4)) t[DST_SZ + i*NUM_LEN +: NUM_LEN] = dg + NUM_LEN'(3);
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  // Active-low segment pattern (bit0 = a); non-decimal nibbles blank.
  function automatic logic [6:0] seg7(input logic [NUM_LEN-1:0] n);
    case (n)
      NUM_LEN'(0): return 7'b1000000;
      NUM_LEN'(1): return 7'b1111001;
      NUM_LEN'(2): return 7'b0100100;
      NUM_LEN'(3): return 7'b0110000;
      NUM_LEN'(4): return 7'b0011001;
      NUM_LEN'(5): return 7'b0010010;
      NUM_LEN'(6): return 7'b0000010;
      NUM_LEN'(7): return 7'b1111000;
      NUM_LEN'(8): return 7'b0000000;
      NUM_LEN'(9): return 7'b0010000;
      default:     return 7'b1111111;
    endcase
  endfunction

  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic              trig_q, trig_d;
  logic              echo_meta_q, echo_sync_q, echo_prev_q;
  logic              echo_rise, echo_fall;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DST_SZ-1:0] cm_q, cm_d;
  logic              strobe_q, strobe_d;
  logic              fl_q, fl_d;
  logic [DST_SZ-1:0] dst_q, dst_d;
  logic              conv_q, conv_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [ITER_W-1:0] it_q, it_d;
  logic              busy_q, busy_d;
  logic [BCD_LEN-1:0] bcd_dst_q, bcd_dst_d;
  logic [REF_W-1:0]  refr_q, refr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_LEN-1:0] nib;

  // Names kept stable for hierarchical probing.
  logic [DST_SZ-1:0]  dst;
  logic [BCD_LEN-1:0] bcd_dst;
  logic               strobe;
  logic               conv;
  logic               busy;
  assign dst     = dst_q;
  assign bcd_dst = bcd_dst_q;
  assign strobe  = strobe_q;
  assign conv    = conv_q;
  assign busy    = busy_q;

  // Trigger period counter; the pulse occupies the first TRIG_LEN counts.
  always_comb begin
    per_cnt_d = '0;
    trig_d    = 1'b0;
    if (!I_EN) begin
      trig_d    = (per_cnt_q < TRIG_END);
      per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
    end
  end

  // Trigger state registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      per_cnt_q <= '0;
      trig_q    <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      trig_q    <= trig_d;
    end
  end

  // Two-flop echo synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_meta_q <= I_ECHO;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
    end
  end

  assign echo_rise = echo_sync_q & ~echo_prev_q;
  assign echo_fall = ~echo_sync_q & echo_prev_q;

  // Echo width measurement: strobe divider, cm counter, result latch.
  always_comb begin
    div_d    = div_q;
    cm_d     = cm_q;
    strobe_d = 1'b0;
    fl_d     = fl_q;
    dst_d    = dst_q;
    conv_d   = 1'b0;
    if (echo_rise) begin
      div_d = '0;
      cm_d  = '0;
      fl_d  = 1'b1;
    end else if (echo_sync_q) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        strobe_d = 1'b1;
        cm_d     = sat_inc(cm_q);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (echo_fall) begin
      fl_d = 1'b0;
      // Holding the display means a finished echo is simply discarded.
      if (!I_EN) begin
        dst_d  = cm_q;
        conv_d = 1'b1;
      end
    end
  end

  // Measurement state registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      div_q    <= '0;
      cm_q     <= '0;
      strobe_q <= 1'b0;
      fl_q     <= 1'b0;
      dst_q    <= '0;
      conv_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      cm_q     <= cm_d;
      strobe_q <= strobe_d;
      fl_q     <= fl_d;
      dst_q    <= dst_d;
      conv_q   <= conv_d;
    end
  end

  // Sequential double-dabble; bcd_dst changes only when all bits are shifted in.
  always_comb begin
    sh_d      = sh_q;
    it_d      = it_q;
    busy_d    = busy_q;
    bcd_dst_d = bcd_dst_q;
    if (busy_q) begin
      sh_d = dd_step(sh_q);
      it_d = it_q + 1'b1;
      if (it_q == ITER_LAST) begin
        busy_d    = 1'b0;
        bcd_dst_d = sh_d[SH_W-1 -: BCD_LEN];
      end
    end else if (conv_q) begin
      sh_d   = {{BCD_LEN{1'b0}}, dst_q};
      it_d   = '0;
      busy_d = 1'b1;
    end
  end

  // Converter state registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sh_q      <= '0;
      it_q      <= '0;
      busy_q    <= 1'b0;
      bcd_dst_q <= '0;
    end else begin
      sh_q      <= sh_d;
      it_q      <= it_d;
      busy_q    <= busy_d;
      bcd_dst_q <= bcd_dst_d;
    end
  end

  // Refresh timer rotating the active digit units -> tens -> hundreds.
  always_comb begin
    refr_d = (refr_q == REF_LAST) ? '0 : refr_q + 1'b1;
    sel_d  = sel_q;
    if (refr_q == REF_LAST) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
  end

  // Display scan registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      refr_q <= '0;
      sel_q  <= '0;
    end else begin
      refr_q <= refr_d;
      sel_q  <= sel_d;
    end
  end

  // Select the nibble of the active digit.
  always_comb begin
    nib = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sel_q == SEL_W'(i)) nib = bcd_dst_q[i*NUM_LEN +: NUM_LEN];
    end
  end

  assign O_MUX_HEX = ~(BCD_DIGITS'(1) << sel_q);
  assign O_HEX     = seg7(nib);
  assign O_TRIG    = trig_q;
  assign O_FL      = fl_q;

endmodule

// File: tb/tb_hc_sr04_top.sv
// Directed bench for hc_sr04_top with shortened timing parameters:
// 20 clocks per cm, 10-clock trigger, 200-clock period, 50-clock digit slot.
module tb_hc_sr04_top;

  logic       CLK;
  logic       RST_n;
  logic       I_EN;
  logic       I_ECHO;
  logic       O_TRIG;
  logic [2:0] O_MUX_HEX;
  logic [6:0] O_HEX;
  logic       O_FL;

  int n_checks = 0;
  int n_errors = 0;

  hc_sr04_top #(
    .STRB_DIV (20),
    .TRIG_LEN (10),
    .MEAS_PER (200),
    .REFR_DIV (50)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .I_EN      (I_EN),
    .I_ECHO    (I_ECHO),
    .O_TRIG    (O_TRIG),
    .O_MUX_HEX (O_MUX_HEX),
    .O_HEX     (O_HEX),
    .O_FL      (O_FL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one echo pulse of w clocks and collect activity until the
  // conversion has had time to finish.
  task automatic echo_pulse(input int w, output int n_strb, output int n_fl,
                            output int n_conv, output int n_busy,
                            output logic [11:0] bcd_at_conv);
    n_strb = 0; n_fl = 0; n_conv = 0; n_busy = 0; bcd_at_conv = 12'hfff;
    @(posedge CLK); #1 I_ECHO = 1'b1;
    for (int k = 1; k <= w + 30; k++) begin
      @(posedge CLK);
      #1 if (k == w) I_ECHO = 1'b0;
      @(negedge CLK);
      if (dut.strobe) n_strb++;
      if (O_FL)       n_fl++;
      if (dut.busy)   n_busy++;
      if (dut.conv) begin
        n_conv++;
        bcd_at_conv = dut.bcd_dst;
      end
    end
  endtask

  // Wait (bounded) for digit i to be selected, then compare its segments.
  task automatic chk_digit(input int i, input logic [6:0] exp, input string tag);
    logic [2:0] want;
    int n;
    want = ~(3'b001 << i);
    n = 0;
    while (O_MUX_HEX !== want && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_sel"}, 32'(n < 200), 32'd1);
    check(tag, 32'(O_HEX), 32'(exp));
  endtask

  int   ns, nf, nc, nb, trig_hi, fl_hi;
  logic [11:0] bc;
  logic [219:0] trig_log;
  logic [2:0]   mux_log [0:219];

  initial begin
    RST_n = 1'b0; I_EN = 1'b0; I_ECHO = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_trig", 32'(O_TRIG), 32'd0);
    check("rst_fl",   32'(O_FL), 32'd0);
    check("rst_dst",  32'(dut.dst), 32'd0);
    check("rst_bcd",  32'(dut.bcd_dst), 32'd0);
    check("rst_conv", 32'(dut.conv), 32'd0);
    check("rst_busy", 32'(dut.busy), 32'd0);
    check("rst_strb", 32'(dut.strobe), 32'd0);
    check("rst_mux",  32'(O_MUX_HEX), 32'h6);
    check("rst_hex",  32'(O_HEX), 32'h40);

    // Trigger timing and digit scan from reset release.
    RST_n = 1'b1;
    fl_hi = 0;
    for (int k = 1; k <= 219; k++) begin
      @(negedge CLK);
      trig_log[k] = O_TRIG;
      mux_log[k]  = O_MUX_HEX;
      if (O_FL) fl_hi++;
    end
    trig_hi = 0;
    for (int k = 1; k <= 200; k++) if (trig_log[k]) trig_hi++;
    check("trig_first",  32'(trig_log[1]), 32'd1);
    check("trig_last",   32'(trig_log[10]), 32'd1);
    check("trig_end",    32'(trig_log[11]), 32'd0);
    check("trig_width",  32'(trig_hi), 32'd10);
    check("trig_period", 32'(trig_log[201]), 32'd1);
    check("idle_fl",     32'(fl_hi), 32'd0);
    check("mux_49",  32'(mux_log[49]),  32'h6);
    check("mux_50",  32'(mux_log[50]),  32'h5);
    check("mux_100", 32'(mux_log[100]), 32'h3);
    check("mux_150", 32'(mux_log[150]), 32'h6);

    // 374 cm: floor((7485-1)/20) = 374.
    echo_pulse(7485, ns, nf, nc, nb, bc);
    check("e374_strb", 32'(ns), 32'd374);
    check("e374_fl",   32'(nf), 32'd7485);
    check("e374_conv", 32'(nc), 32'd1);
    check("e374_busy", 32'(nb), 32'd9);
    check("e374_dst",  32'(dut.dst), 32'd374);
    check("e374_bcd",  32'(dut.bcd_dst), 32'h374);
    chk_digit(0, 7'h19, "e374_d0");
    chk_digit(1, 7'h78, "e374_d1");
    chk_digit(2, 7'h30, "e374_d2");

    // 187 cm; previous BCD value still shown when the conversion starts.
    echo_pulse(3750, ns, nf, nc, nb, bc);
    check("e187_strb", 32'(ns), 32'd187);
    check("e187_old",  32'(bc), 32'h374);
    check("e187_dst",  32'(dut.dst), 32'd187);
    check("e187_bcd",  32'(dut.bcd_dst), 32'h187);
    chk_digit(0, 7'h78, "e187_d0");
    chk_digit(1, 7'h00, "e187_d1");
    chk_digit(2, 7'h79, "e187_d2");

    // Shorter than one cm.
    echo_pulse(15, ns, nf, nc, nb, bc);
    check("short_strb", 32'(ns), 32'd0);
    check("short_dst",  32'(dut.dst), 32'd0);
    check("short_bcd",  32'(dut.bcd_dst), 32'h000);

    // 404 strobes worth of echo saturates at 400 cm.
    echo_pulse(8100, ns, nf, nc, nb, bc);
    check("sat_strb", 32'(ns), 32'd404);
    check("sat_dst",  32'(dut.dst), 32'd400);
    check("sat_bcd",  32'(dut.bcd_dst), 32'h400);
    chk_digit(0, 7'h40, "sat_d0");
    chk_digit(2, 7'h19, "sat_d2");

    // Hold mode: no triggers, echo measured but result discarded.
    @(posedge CLK); #1 I_EN = 1'b1;
    @(posedge CLK);
    trig_hi = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge CLK);
      if (O_TRIG) trig_hi++;
    end
    check("hold_trig", 32'(trig_hi), 32'd0);
    echo_pulse(2000, ns, nf, nc, nb, bc);
    check("hold_fl",   32'(nf), 32'd2000);
    check("hold_conv", 32'(nc), 32'd0);
    check("hold_dst",  32'(dut.dst), 32'd400);
    check("hold_bcd",  32'(dut.bcd_dst), 32'h400);

    // Reset in the middle of an echo.
    @(posedge CLK); #1 I_EN = 1'b0; I_ECHO = 1'b1;
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    check("mid_fl_on", 32'(O_FL), 32'd1);
    @(posedge CLK); #1 RST_n = 1'b0;
    #1;
    check("mid_rst_fl",  32'(O_FL), 32'd0);
    check("mid_rst_dst", 32'(dut.dst), 32'd0);
    check("mid_rst_bcd", 32'(dut.bcd_dst), 32'd0);
    I_ECHO = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    repeat (5) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
